// File: rtl/mfcc_rom_defs.sv
// Shared definitions for the melbank ROM read path.
//   MELROM_ADDR_WIDTH / MELROM_DATA_WIDTH : default geometry of the melbank ROMs
//   rd_state_e                            : read initiator command states
package mfcc_rom_defs;

  localparam int MELROM_ADDR_WIDTH = 8;
  localparam int MELROM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/mfcc_melbank_rom_reader_if.sv
// Coefficient stream from the ROM reader to the mel-energy MAC.
//   m_valid/m_ready : handshake, beat moves when both are 1
//   m_data          : coefficient word
//   m_index         : 0-based beat index within the command
//   m_last          : final beat of the command
// master = reader side, slave = consumer side.
interface mfcc_melbank_rom_reader_if
  import mfcc_rom_defs::*;
#(
  parameter int ADDR_WIDTH = MELROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MELROM_DATA_WIDTH
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH:0]   m_index;
  logic                  m_last;

  modport master (
    output m_valid, m_data, m_index, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_index, m_last,
    output m_ready
  );

endinterface

// File: rtl/mfcc_rom_rd_fifo.sv
// Return buffer for ROM words: synchronous FIFO, output taken from registered
// storage so a push is visible on the read side one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push_i/din_i : write strobe and word
//   pop_i        : read strobe, ignored when empty
//   dout_o       : head word
//   empty_o, full_o, count_o : occupancy flags
module mfcc_rom_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // a pop frees the slot being written, so push+pop on a full FIFO is fine
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mfcc_melbank_rom_reader.sv
// Read initiator for the melbank coefficient ROMs. A start command walks a
// contiguous (wrapping) address window, tracks the ROM read latency, buffers
// returned words and presents them as a valid/ready stream with index/last.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, start_addr, length : command (accepted in IDLE only)
//   busy, done          : command in progress / one-cycle completion pulse
//   rom_addr, rom_data  : ROM port (registered address, data after ROM_LATENCY)
//   m                   : coefficient stream (master side)
module mfcc_melbank_rom_reader
  import mfcc_rom_defs::*;
#(
  parameter int ADDR_WIDTH  = MELROM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = MELROM_DATA_WIDTH,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     start_addr,
  input  logic [ADDR_WIDTH:0]       length,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data,
  mfcc_melbank_rom_reader_if.master m
);

  localparam int PIPE_W = ROM_LATENCY + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = 1 + (ADDR_WIDTH + 1) + DATA_WIDTH;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   pushed_q, pushed_d;
  // bit 0: rom_addr holds a freshly issued address; bit ROM_LATENCY: its
  // data is on rom_data this cycle and gets pushed
  logic [PIPE_W-1:0]     pipe_q, pipe_d;

  logic                  issue, push, pop, credit;
  logic [CNT_W-1:0]      inflight, fifo_count;
  logic [CNT_W:0]        occupancy;
  logic                  fifo_empty, fifo_full;
  logic [FIFO_W-1:0]     fifo_din, fifo_dout;

  assign push     = pipe_q[ROM_LATENCY];
  assign pop      = m.m_valid & m.m_ready;
  assign fifo_din = {(pushed_q == len_q - 1'b1), pushed_q, rom_data};

  // Credit uses registered occupancy only, so m_ready never reaches rom_addr.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < PIPE_W; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
    occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    credit    = ~fifo_full && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rom_addr_d = rom_addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    pushed_d   = pushed_q;
    issue      = 1'b0;
    pipe_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = length;
          pushed_d = '0;
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            // first address goes out straight from IDLE (pipeline empty,
            // FIFO drained) so rom_addr is valid the cycle after start
            issue      = 1'b1;
            rom_addr_d = start_addr;
            addr_d     = start_addr + 1'b1;
            issued_d   = (ADDR_WIDTH+1)'(1);
            state_d    = (length == (ADDR_WIDTH+1)'(1)) ? ST_DRAIN : ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (credit) begin
          issue      = 1'b1;
          rom_addr_d = addr_q;
          addr_d     = addr_q + 1'b1;
          issued_d   = issued_q + 1'b1;
          if (issued_q + 1'b1 == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((inflight == '0) && pop && m.m_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push) begin
      pushed_d = pushed_q + 1'b1;
    end

    pipe_d[0] = issue;
    for (int unsigned i = 1; i < PIPE_W; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rom_addr_q <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      pushed_q   <= '0;
      pipe_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      pushed_q   <= pushed_d;
      pipe_q     <= pipe_d;
    end
  end

  mfcc_rom_rd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign rom_addr  = rom_addr_q;
  assign m.m_valid = ~fifo_empty;
  assign {m.m_last, m.m_index, m.m_data} = fifo_dout;

endmodule
